job_ctrl: RTL and testbench

//  Owns the PSL job-control interface (ha_j*/ah_j*) for the AFU. Decodes job commands
//  (reset, start, LLCMD), holds the job state machine and reports jrunning/jdone/jerror.

---
 rtl/capi_pkg.sv | 26 ++
 rtl/job_ctrl.sv | 170 +++++++++++++++++
 tb/tb_job_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/capi_pkg.sv
// Shared definitions for the PSL job-control interface: command codes, error codes,
// job state encoding and the odd-parity helper.
package capi_pkg;

    localparam logic [7:0]  JCOM_RESET = 8'h80;
    localparam logic [7:0]  JCOM_START = 8'h90;
    localparam logic [7:0]  JCOM_LLCMD = 8'h45;

    localparam logic [63:0] JERR_JCOM_PAR   = 64'h1;
    localparam logic [63:0] JERR_JEA_PAR    = 64'h2;
    localparam logic [63:0] JERR_START_BUSY = 64'h4;
    localparam logic [63:0] JERR_NOT_ARMED  = 64'h8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESETTING = 2'd1,
        ST_RUNNING   = 2'd2,
        ST_FINISH    = 2'd3
    } job_state_t;

    // Odd parity holds when data and its parity bit together carry an odd number of ones.
    function automatic logic odd_par_ok(input logic [63:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/job_ctrl.sv
// PSL job-control front end: decodes jcom, runs the job state machine and sequences
// the AFU core through core_reset/core_start/core_done. Every output is a flop.
module job_ctrl
    import capi_pkg::*;
#(
    parameter int RESET_CYCLES = 8,
    parameter int PARITY_EN    = 1
) (
    input  logic        ha_pclock,
    input  logic        ha_preset_n,
    input  logic        ha_jval,
    input  logic [7:0]  ha_jcom,
    input  logic        ha_jcompar,
    input  logic [63:0] ha_jea,
    input  logic        ha_jeapar,
    output logic        ah_jrunning,
    output logic        ah_jdone,
    output logic        ah_jcack,
    output logic [63:0] ah_jerror,
    output logic        ah_jyield,
    output logic        ah_paren,
    output logic        core_reset,
    output logic        core_start,
    output logic [63:0] core_ea,
    input  logic        core_done,
    input  logic [63:0] core_error
);

    localparam int               CNT_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES);

    job_state_t       state_q, state_d;
    logic             armed_q, armed_d;
    logic [63:0]      sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             jrunning_q, jdone_q, jdone_d, jcack_q, jcack_d;
    logic [63:0]      jerror_q, jerror_d;
    logic             core_reset_q, core_start_q, core_start_d;
    logic [63:0]      core_ea_q, core_ea_d;
    logic             jcom_bad_s, jea_bad_s, start_busy_s;

    assign jcom_bad_s   = (PARITY_EN != 0) && !odd_par_ok({56'h0, ha_jcom}, ha_jcompar);
    assign jea_bad_s    = (PARITY_EN != 0) && (ha_jcom == JCOM_START) && !odd_par_ok(ha_jea, ha_jeapar);
    assign start_busy_s = ha_jval && (ha_jcom == JCOM_START) && (state_q == ST_RUNNING);

    // Next-state decode; a jval command is applied last so it overrides the state's own progress.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        sticky_d     = sticky_q;
        cnt_d        = (cnt_q != {CNT_W{1'b0}}) ? cnt_q - CNT_W'(1) : {CNT_W{1'b0}};
        core_ea_d    = core_ea_q;
        core_start_d = 1'b0;
        jcack_d      = 1'b0;
        jdone_d      = 1'b0;
        jerror_d     = 64'h0;
        case (state_q)
            ST_RESETTING: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = ST_FINISH;
                    jdone_d  = 1'b1;
                    armed_d  = 1'b1;
                    sticky_d = 64'h0;
                end else begin
                    state_d = ST_RESETTING;
                end
            end
            ST_RUNNING: begin
                if (core_done) begin
                    state_d  = ST_FINISH;
                    jdone_d  = 1'b1;
                    jerror_d = core_error | sticky_q | (start_busy_s ? JERR_START_BUSY : 64'h0);
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_IDLE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (ha_jval) begin
            if (jcom_bad_s || jea_bad_s) begin
                // Corrupted command: abort whatever runs, flush the core and disarm.
                state_d  = ST_FINISH;
                jdone_d  = 1'b1;
                jerror_d = jcom_bad_s ? JERR_JCOM_PAR : JERR_JEA_PAR;
                armed_d  = 1'b0;
                cnt_d    = CNT_LOAD;
            end else begin
                case (ha_jcom)
                    JCOM_RESET: begin
                        state_d  = ST_RESETTING;
                        cnt_d    = CNT_LOAD;
                        jdone_d  = 1'b0;
                        jerror_d = 64'h0;
                    end
                    JCOM_START: begin
                        case (state_q)
                            ST_IDLE: begin
                                if (armed_q) begin
                                    state_d      = ST_RUNNING;
                                    core_start_d = 1'b1;
                                    core_ea_d    = ha_jea;
                                    sticky_d     = 64'h0;
                                end else begin
                                    state_d  = ST_FINISH;
                                    jdone_d  = 1'b1;
                                    jerror_d = JERR_NOT_ARMED;
                                end
                            end
                            ST_RUNNING: sticky_d = sticky_q | JERR_START_BUSY;
                            default:    sticky_d = sticky_q;
                        endcase
                    end
                    JCOM_LLCMD: begin
                        if (state_q == ST_RUNNING) begin
                            jcack_d = 1'b1;
                        end else begin
                            jcack_d = 1'b0;
                        end
                    end
                    default: jcack_d = 1'b0;
                endcase
            end
        end else begin
            jcack_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            sticky_q     <= 64'h0;
            cnt_q        <= {CNT_W{1'b0}};
            jrunning_q   <= 1'b0;
            jdone_q      <= 1'b0;
            jcack_q      <= 1'b0;
            jerror_q     <= 64'h0;
            core_reset_q <= 1'b0;
            core_start_q <= 1'b0;
            core_ea_q    <= 64'h0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            sticky_q     <= sticky_d;
            cnt_q        <= cnt_d;
            jrunning_q   <= (state_d == ST_RUNNING);
            jdone_q      <= jdone_d;
            jcack_q      <= jcack_d;
            jerror_q     <= jerror_d;
            core_reset_q <= (cnt_d != {CNT_W{1'b0}});
            core_start_q <= core_start_d;
            core_ea_q    <= core_ea_d;
        end
    end

    assign ah_jrunning = jrunning_q;
    assign ah_jdone    = jdone_q;
    assign ah_jcack    = jcack_q;
    assign ah_jerror   = jerror_q;
    assign ah_jyield   = 1'b0;
    assign ah_paren    = (PARITY_EN != 0) ? 1'b1 : 1'b0;
    assign core_reset  = core_reset_q;
    assign core_start  = core_start_q;
    assign core_ea     = core_ea_q;

endmodule

// File: tb/tb_job_ctrl.sv
// Scoreboard bench for job_ctrl: a transaction-level job model queues expected
// done/start/cack events; a negedge monitor matches them against the DUT.
module tb_job_ctrl;
    import capi_pkg::*;

    localparam int RC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ha_jval, ha_jcompar, ha_jeapar, core_done;
    logic [7:0]  ha_jcom;
    logic [63:0] ha_jea, core_error;
    logic        ah_jrunning, ah_jdone, ah_jcack, ah_jyield, ah_paren;
    logic        core_reset, core_start;
    logic [63:0] ah_jerror, core_ea;

    job_ctrl #(.RESET_CYCLES(RC), .PARITY_EN(1)) dut (
        .ha_pclock(clk), .ha_preset_n(rst_n), .ha_jval(ha_jval), .ha_jcom(ha_jcom),
        .ha_jcompar(ha_jcompar), .ha_jea(ha_jea), .ha_jeapar(ha_jeapar),
        .ah_jrunning(ah_jrunning), .ah_jdone(ah_jdone), .ah_jcack(ah_jcack),
        .ah_jerror(ah_jerror), .ah_jyield(ah_jyield), .ah_paren(ah_paren),
        .core_reset(core_reset), .core_start(core_start), .core_ea(core_ea),
        .core_done(core_done), .core_error(core_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 done, 1 core_start, 2 jcack
        int          cyc;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_armed = 1'b0;
    bit          m_running = 1'b0;
    logic [63:0] m_sticky = 64'h0;
    logic [63:0] m_ea = 64'h0;
    int          m_rst_done = -100;
    int          m_fin = -100;
    int          m_cr_until = -100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int k, input int c, input logic [63:0] v);
        exp_t t;
        t.kind = k; t.cyc = c; t.val = v;
        exp_q.push_back(t);
    endtask

    task automatic cancel_reset_done();
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].kind == 0 && exp_q[i].cyc == m_rst_done) idx = i;
        if (idx >= 0) exp_q.delete(idx);
        m_rst_done = -100;
    endtask

    task automatic parity_abort(input int e, input logic [63:0] code, input bit resetting);
        if (resetting) cancel_reset_done();
        m_running  = 1'b0;
        m_armed    = 1'b0;
        m_fin      = e;
        m_cr_until = e + RC - 1;
        push(0, e, code);
    endtask

    // Job-level reference: applies the command/done seen at edge e to the abstract job.
    task automatic model_edge(input bit jv, input logic [7:0] code, input bit cpar_ok,
                              input logic [63:0] jea, input bit epar_ok,
                              input bit done, input logic [63:0] cerr);
        int e = cyc;
        bit resetting = (e <= m_rst_done);
        bit fin = (e == m_fin + 1) || (e == m_rst_done + 1);
        bit was_run = m_running;
        if (jv && !cpar_ok) parity_abort(e, 64'h1, resetting);
        else if (jv && code == JCOM_START && !epar_ok) parity_abort(e, 64'h2, resetting);
        else if (jv && code == JCOM_RESET) begin
            if (resetting) cancel_reset_done();
            m_running  = 1'b0;
            m_armed    = 1'b1;
            m_sticky   = 64'h0;
            m_rst_done = e + RC;
            m_cr_until = e + RC - 1;
            push(0, e + RC, 64'h0);
        end else begin
            if (jv && code == JCOM_START && was_run) m_sticky = m_sticky | 64'h4;
            if (was_run && done) begin
                push(0, e, cerr | m_sticky);
                m_fin = e;
                m_running = 1'b0;
            end
            if (jv && code == JCOM_START && !was_run && !resetting && !fin) begin
                if (m_armed) begin
                    push(1, e, jea);
                    m_ea = jea; m_running = 1'b1; m_sticky = 64'h0;
                end else begin
                    push(0, e, 64'h8);
                    m_fin = e;
                end
            end
            if (jv && code == JCOM_LLCMD && was_run) push(2, e, 64'h0);
        end
    endtask

    task automatic cycle_drive(input bit jv, input logic [7:0] code, input bit cpar_ok,
                               input logic [63:0] jea, input bit epar_ok,
                               input bit done, input logic [63:0] cerr);
        @(negedge clk);
        ha_jval    = jv;
        ha_jcom    = code;
        ha_jcompar = cpar_ok ? ~^code : ^code;
        ha_jea     = jea;
        ha_jeapar  = epar_ok ? ~^jea : ^jea;
        core_done  = done;
        core_error = cerr;
        @(posedge clk);
        #1;
        model_edge(jv, code, cpar_ok, jea, epar_ok, done, cerr);
        ha_jval   = 1'b0;
        core_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_drive(1'b0, 8'h00, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0);
    endtask

    task automatic cmd(input logic [7:0] code, input logic [63:0] jea);
        cycle_drive(1'b1, code, 1'b1, jea, 1'b1, 1'b0, 64'h0);
    endtask

    task automatic finish_job(input logic [63:0] cerr);
        cycle_drive(1'b0, 8'h00, 1'b1, 64'h0, 1'b1, 1'b1, cerr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_jrunning"}, ah_jrunning, 64'h0);
        check({tag, "_jdone"}, ah_jdone, 64'h0);
        check({tag, "_jcack"}, ah_jcack, 64'h0);
        check({tag, "_jerror"}, ah_jerror, 64'h0);
        check({tag, "_core_reset"}, core_reset, 64'h0);
        check({tag, "_core_start"}, core_start, 64'h0);
        check({tag, "_core_ea"}, core_ea, 64'h0);
        check({tag, "_jyield"}, ah_jyield, 64'h0);
        check({tag, "_paren"}, ah_paren, 64'h1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_armed = 1'b0; m_running = 1'b0; m_sticky = 64'h0; m_ea = 64'h0;
        m_rst_done = -100; m_fin = -100; m_cr_until = -100;
    endtask

    // Monitor: match pulsed events against the scoreboard and levels against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                int          idx;
                bit          seen, exp_now;
                logic [63:0] act;
                string       nm;
                case (k)
                    0:       begin seen = ah_jdone;   act = ah_jerror; nm = "jdone";      end
                    1:       begin seen = core_start; act = core_ea;   nm = "core_start"; end
                    default: begin seen = ah_jcack;   act = 64'h0;     nm = "jcack";      end
                endcase
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (idx < 0 && exp_q[i].kind == k) idx = i;
                exp_now = (idx >= 0) && (exp_q[idx].cyc == cyc);
                check({nm, "_pulse"}, seen, exp_now);
                if (seen && exp_now && k != 2) check({nm, "_value"}, act, exp_q[idx].val);
                if (idx >= 0 && exp_q[idx].cyc <= cyc) exp_q.delete(idx);
            end
            check("jrunning", ah_jrunning, m_running);
            check("core_reset", core_reset, (cyc <= m_cr_until));
            check("core_ea_hold", core_ea, m_ea);
            if (!ah_jdone) check("jerror_quiet", ah_jerror, 64'h0);
        end
    end

    initial begin
        logic [7:0] codes [4];
        logic [7:0] c;
        codes[0] = JCOM_RESET; codes[1] = JCOM_START; codes[2] = JCOM_LLCMD; codes[3] = 8'h3c;
        rst_n = 1'b0;
        ha_jval = 1'b0; ha_jcom = 8'h00; ha_jcompar = 1'b1; ha_jea = 64'h0; ha_jeapar = 1'b1;
        core_done = 1'b0; core_error = 64'h0;
        #3;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // START before any reset is rejected as unarmed
        cmd(JCOM_START, 64'h2000); idle(2);
        // RESET sequence, then a clean job
        cmd(JCOM_RESET, 64'h0); idle(RC + 2);
        cmd(JCOM_START, 64'h1000); idle(3); finish_job(64'h0); idle(2);
        // LLCMD ack and a second START folded into the done error
        cmd(JCOM_START, 64'hdead_beef_0000_1000); idle(2); cmd(JCOM_LLCMD, 64'h0); idle(1);
        cmd(JCOM_START, 64'h5555); idle(1); finish_job(64'h10); idle(2);
        // jcom parity error while running, then START is unarmed
        cmd(JCOM_START, 64'h40); idle(2);
        cycle_drive(1'b1, JCOM_LLCMD, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0); idle(2);
        cmd(JCOM_START, 64'h80); idle(RC + 2);
        // RESET coincident with core_done: only the reset completion is reported
        cmd(JCOM_RESET, 64'h0); idle(RC + 2);
        cmd(JCOM_START, 64'h3000); idle(3);
        cycle_drive(1'b1, JCOM_RESET, 1'b1, 64'h0, 1'b1, 1'b1, 64'h55); idle(RC + 2);
        // RESET restarted mid-sequence, START during RESETTING ignored, jea parity error
        cmd(JCOM_RESET, 64'h0); idle(3); cmd(JCOM_RESET, 64'h0); idle(2);
        cmd(JCOM_START, 64'h7000); idle(RC + 2);
        cycle_drive(1'b1, JCOM_START, 1'b1, 64'h9000, 1'b0, 1'b0, 64'h0); idle(RC + 2);
        // Asynchronous reset in the middle of RESETTING
        cmd(JCOM_RESET, 64'h0); idle(3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmd(JCOM_START, 64'h1); idle(2);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 8))
                0: begin cmd(JCOM_RESET, 64'h0); idle(RC + 1); end
                1, 8: cmd(JCOM_START, {$urandom, $urandom});
                2: cmd(JCOM_LLCMD, 64'h0);
                3: finish_job({$urandom, $urandom});
                4: cycle_drive(1'b1, codes[$urandom_range(0, 3)], 1'b0, {$urandom, $urandom}, 1'b1, 1'b0, 64'h0);
                5: cycle_drive(1'b1, JCOM_START, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 64'h0);
                6: begin
                    c = 8'($urandom);
                    if (c == JCOM_RESET || c == JCOM_START || c == JCOM_LLCMD) c = 8'h11;
                    cmd(c, {$urandom, $urandom});
                end
                default: idle(1);
            endcase
            idle(1);
        end
        idle(RC + 4);
        check("scoreboard_drained", exp_q.size(), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
